ikbd_quad_gen: RTL and testbench
================================

# ikbd_quad_gen

Parametrised multi-axis quadrature generator for the ikbd input path. It accepts signed relative motion deltas, such as decoded PS/2 mouse packets or trackball/paddle counts, on any number of axes. It accumulates them with saturation and replays them as rate-limited two-phase quadrature (XA/XB, YA/YB, …) on the 6301 input port, exactly as a real Atari mouse does. It generalises the fixed two-axis mouse quadrature feed to NUM_AXES channels, configurable step rate, sticky overflow and clear.

## Interface
- NUM_AXES, 2, number of independent quadrature channels
- DELTA_W, 9, width of each signed input delta (PS/2 native 9-bit)
- ACC_W, 12, width of each signed accumulator; must be ≥ DELTA_W+1
- DIV_W, 16, width of the step-period divider input

- clk  in  1  system clock (2 MHz in the ikbd)
- res  in  1  synchronous, active-low reset (0 = reset)
- delta_valid  in  1  one-cycle strobe; all axis deltas sampled this cycle
- delta  in  NUM_AXES*DELTA_W  packed signed deltas, axis i at [i*DELTA_W +: DELTA_W]
- step_div  in  DIV_W  clk cycles per quadrature step; 0 treated as 1
- clear  in  1  zero all accumulators and overflow flags; phase retained
- quad  out  2*NUM_AXES  quadrature outputs, axis i = {B,A} at [2i+1:2i]
- busy  out  1  high while any accumulator is non-zero
- overflow  out  NUM_AXES  sticky per-axis saturation flag

## Operation
- Prescaler: counter 0..max(step_div,1)-1; `tick` is asserted in the cycle the counter equals the terminal value, then the counter wraps to 0. If step_div is lowered below the current count, the counter wraps to 0 on the next cycle without a tick.
- Per-axis accumulator acc (signed ACC_W), contribution d = sign-extended delta on delta_valid, else 0. Step s = +1 if tick and acc>0, −1 if tick and acc<0, else 0.
- acc_next = sat(acc + d − s), saturating at ±(2^(ACC_W−1)−1). If saturation clipped, overflow[i] is set and holds until clear or reset.
- Phase: 2-bit counter per axis; phase += 1 when s=+1, phase −= 1 when s=−1, wraps mod 4.
- Gray encoding {B,A}: phase 0→00, 1→01, 2→11, 3→10 (A = phase[1]^phase[0], B = phase[1]).
- Exactly one output bit changes per step. At most one step per axis per tick.
- clear takes priority over delta_valid in the same cycle. acc goes to 0 and any delta that cycle is discarded. Phase and prescaler are unaffected.
- Simultaneous delta_valid and tick: both are applied in one update, using the step derived from the pre-update acc.
- busy = OR over axes of (acc ≠ 0), registered.

## Timing
- Reset (res=0 at a clk edge): acc=0, phase=0, quad=0, prescaler=0, overflow=0, busy=0. Any in-flight motion is dropped.
- delta_valid in cycle n: acc reflects it in cycle n+1, busy high in n+1 when non-zero.
- First quad change occurs in the cycle after the first tick at or after n+1.
- After reset with constant step_div=D≥1, ticks fall on cycles D, 2D, … after res deasserts. quad changes one cycle after each tick (all outputs registered).
- Maximum edge rate per axis is clk/max(step_div,1).
- No backpressure: delta_valid is accepted every cycle, including back-to-back.

## Structure
- Package ikbd_quad_pkg holds:
  - the Gray phase encode function,
  - the signed saturating add function (parametrised by width),
  - phase constants PH_00/PH_01/PH_11/PH_10.
- Sub-module ikbd_quad_axis: one accumulator, phase counter and overflow flag. It is instantiated NUM_AXES times in a generate loop.
- The top level owns only the shared prescaler, `busy` reduction and port packing.

## Test plan
- Reset/idle: hold res=0 3 cycles, release, step_div=4, no deltas → quad=0, busy=0, overflow=0 for 100 cycles.
- Positive/negative motion: step_div=4, axis0 delta=+3, axis1 delta=−2 in one strobe → axis0 {B,A} sequence 01,11,10 at 4-cycle spacing. Axis1 sequence 10,11 (reverse). busy falls after axis0's third step.
- Simultaneous events: delta_valid +1 on a tick cycle with acc=+2 → acc=+2 next cycle, one step taken. clear with delta_valid → acc=0, delta ignored, phase unchanged.
- Saturation: ACC_W=12, sixteen strobes of +255 (4080) then +255 → acc=2047, overflow[0]=1. The flag holds until clear; clear drops it the next cycle.
- Divider edge cases: step_div=0 → step every cycle. Change step_div 100→3 with counter at 50 → wrap to 0 with no tick, then ticks every 3 cycles.
- Reset mid-motion: acc=+40 and steps in progress, res=0 one cycle → quad=0, acc=0, busy=0 next cycle. No further edges.

Source files
------------

// File: rtl/ikbd_quad_pkg.sv
// rtl/ikbd_quad_pkg.sv - shared constants and helpers for the ikbd quadrature generator
package ikbd_quad_pkg;

    // Quadrature {B,A} levels for each phase
    localparam logic [1:0] PH_00 = 2'b00;
    localparam logic [1:0] PH_01 = 2'b01;
    localparam logic [1:0] PH_11 = 2'b11;
    localparam logic [1:0] PH_10 = 2'b10;

    // Result of a saturating add: clipped flags that the limit was applied
    typedef struct packed {
        logic               clipped;
        logic signed [31:0] value;
    } sat_t;

    // Phase to Gray {B,A}; one bit changes between neighbouring phases
    function automatic logic [1:0] gray_enc(input logic [1:0] ph);
        case (ph)
            2'd0:    return PH_00;
            2'd1:    return PH_01;
            2'd2:    return PH_11;
            default: return PH_10;
        endcase
    endfunction

    // Signed add clipped symmetrically to +/-(2^(w-1)-1); w must be <= 31
    function automatic sat_t sat_add(input logic signed [31:0] a,
                                     input logic signed [31:0] b,
                                     input int w);
        logic signed [31:0] lim;
        logic signed [32:0] sum;
        sat_t r;
        lim       = (32'sd1 <<< (w - 1)) - 32'sd1;
        sum       = 33'(a) + 33'(b);
        r.clipped = 1'b0;
        r.value   = 32'(sum);
        if (sum > 33'(lim)) begin
            r.clipped = 1'b1;
            r.value   = lim;
        end else if (sum < -33'(lim)) begin
            r.clipped = 1'b1;
            r.value   = -lim;
        end
        return r;
    endfunction

endpackage

// File: rtl/ikbd_quad_gen_if.sv
// rtl/ikbd_quad_gen_if.sv - motion input / quadrature output bundle
interface ikbd_quad_gen_if #(
    parameter int NUM_AXES = 2,
    parameter int DELTA_W  = 9,
    parameter int DIV_W    = 16
);
    logic                          delta_valid;
    logic [NUM_AXES*DELTA_W-1:0]   delta;
    logic [DIV_W-1:0]              step_div;
    logic                          clear;
    logic [2*NUM_AXES-1:0]         quad;
    logic                          busy;
    logic [NUM_AXES-1:0]           overflow;

    modport master (
        output delta_valid, delta, step_div, clear,
        input  quad, busy, overflow
    );

    modport slave (
        input  delta_valid, delta, step_div, clear,
        output quad, busy, overflow
    );
endinterface

// File: rtl/ikbd_quad_axis.sv
// rtl/ikbd_quad_axis.sv - one axis: saturating accumulator, phase counter, overflow flag
module ikbd_quad_axis
    import ikbd_quad_pkg::*;
#(
    parameter int DELTA_W = 9,
    parameter int ACC_W   = 12
) (
    input  logic               clk,
    input  logic               res,
    input  logic               i_tick,
    input  logic               i_delta_valid,
    input  logic [DELTA_W-1:0] i_delta,
    input  logic               i_clear,
    output logic [1:0]         o_quad,
    output logic               o_nz,
    output logic               o_overflow
);

    logic signed [ACC_W-1:0]   r_acc;
    logic [1:0]                r_phase;
    logic [1:0]                r_quad;
    logic                      r_nz;
    logic                      r_ovf;

    logic signed [DELTA_W-1:0] w_delta_s;
    logic signed [31:0]        w_acc32;
    logic signed [31:0]        w_d;
    logic signed [31:0]        w_s;
    logic                      w_up;
    logic                      w_dn;
    sat_t                      w_sat;
    logic signed [ACC_W-1:0]   w_acc_next;
    logic [1:0]                w_phase_next;

    // Step direction comes from the pre-update accumulator; clear freezes the phase
    assign w_delta_s    = i_delta;
    assign w_acc32      = 32'(r_acc);
    assign w_up         = i_tick && !i_clear && (w_acc32 > 32'sd0);
    assign w_dn         = i_tick && !i_clear && (w_acc32 < 32'sd0);
    assign w_d          = i_delta_valid ? 32'(w_delta_s) : 32'sd0;
    assign w_s          = w_up ? 32'sd1 : (w_dn ? -32'sd1 : 32'sd0);
    assign w_sat        = sat_add(w_acc32, w_d - w_s, ACC_W);
    assign w_acc_next   = ACC_W'(w_sat.value);
    assign w_phase_next = w_up ? r_phase + 2'd1 : (w_dn ? r_phase - 2'd1 : r_phase);

    // Accumulator, phase, registered quadrature and sticky overflow
    always_ff @(posedge clk) begin
        if (!res) begin
            r_acc   <= '0;
            r_phase <= 2'd0;
            r_quad  <= PH_00;
            r_nz    <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_phase <= w_phase_next;
            r_quad  <= gray_enc(w_phase_next);
            if (i_clear) begin
                r_acc <= '0;
                r_nz  <= 1'b0;
                r_ovf <= 1'b0;
            end else begin
                r_acc <= w_acc_next;
                r_nz  <= (w_acc_next != '0);
                r_ovf <= r_ovf | w_sat.clipped;
            end
        end
    end

    assign o_quad     = r_quad;
    assign o_nz       = r_nz;
    assign o_overflow = r_ovf;

endmodule

// File: rtl/ikbd_quad_gen.sv
// rtl/ikbd_quad_gen.sv - multi-axis rate-limited quadrature generator top
module ikbd_quad_gen
    import ikbd_quad_pkg::*;
#(
    parameter int NUM_AXES = 2,
    parameter int DELTA_W  = 9,
    parameter int ACC_W    = 12,
    parameter int DIV_W    = 16
) (
    input  logic            clk,
    input  logic            res,
    ikbd_quad_gen_if.slave  bus
);

    logic [DIV_W-1:0]    r_cnt;
    logic [DIV_W-1:0]    w_term;
    logic                w_tick;
    logic [NUM_AXES-1:0] w_nz;

    // A divider of 0 behaves as 1, so the terminal count is 0 in both cases
    assign w_term = (bus.step_div == '0) ? '0 : bus.step_div - DIV_W'(1);
    assign w_tick = (r_cnt == w_term);

    // Shared prescaler; a count above a freshly lowered terminal wraps without a tick
    always_ff @(posedge clk) begin
        if (!res) begin
            r_cnt <= '0;
        end else if (r_cnt >= w_term) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + DIV_W'(1);
        end
    end

    for (genvar i = 0; i < NUM_AXES; i++) begin : g_axis
        ikbd_quad_axis #(
            .DELTA_W (DELTA_W),
            .ACC_W   (ACC_W)
        ) u_axis (
            .clk           (clk),
            .res           (res),
            .i_tick        (w_tick),
            .i_delta_valid (bus.delta_valid),
            .i_delta       (bus.delta[i*DELTA_W +: DELTA_W]),
            .i_clear       (bus.clear),
            .o_quad        (bus.quad[2*i +: 2]),
            .o_nz          (w_nz[i]),
            .o_overflow    (bus.overflow[i])
        );
    end

    assign bus.busy = |w_nz;

endmodule

// File: tb/tb_ikbd_quad_gen.sv
// tb/tb_ikbd_quad_gen.sv - directed self-checking bench for ikbd_quad_gen
module tb_ikbd_quad_gen;
    localparam int NA = 2;
    localparam int DW = 9;
    localparam int AW = 12;
    localparam int VW = 16;

    logic clk = 1'b0;
    logic res = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   ecount = 0;

    ikbd_quad_gen_if #(.NUM_AXES(NA), .DELTA_W(DW), .DIV_W(VW)) bus ();

    ikbd_quad_gen #(.NUM_AXES(NA), .DELTA_W(DW), .ACC_W(AW), .DIV_W(VW)) dut (
        .clk (clk),
        .res (res),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
        ecount++;
    endtask

    task automatic run_to(input int e);
        while (ecount < e) cyc();
    endtask

    task automatic idle();
        bus.delta_valid = 1'b0;
        bus.delta       = '0;
        bus.clear       = 1'b0;
    endtask

    task automatic set_delta(input int d0, input int d1);
        logic [DW-1:0] a0;
        logic [DW-1:0] a1;
        a0 = DW'(d0);
        a1 = DW'(d1);
        bus.delta_valid = 1'b1;
        bus.delta       = {a1, a0};
    endtask

    task automatic do_reset(input int div);
        res          = 1'b0;
        bus.step_div = VW'(div);
        idle();
        cyc();
        res    = 1'b1;
        ecount = 0;
    endtask

    task automatic test_reset();
        int bad;
        res          = 1'b0;
        bus.step_div = 16'd4;
        idle();
        repeat (3) cyc();
        checks++; if (bus.quad !== 4'b0000) begin errors++; $display("FAIL reset_quad got=%b exp=0000", bus.quad); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.overflow !== 2'b00) begin errors++; $display("FAIL reset_ovf got=%b exp=00", bus.overflow); end
        res = 1'b1;
        bad = 0;
        repeat (100) begin
            cyc();
            if (bus.quad !== 4'b0000 || bus.busy !== 1'b0 || bus.overflow !== 2'b00) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL idle_quiet bad_cycles=%0d exp=0", bad); end
    endtask

    task automatic test_motion();
        do_reset(4);
        set_delta(3, -2); cyc(); idle();
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL motion_busy_e1 got=%b exp=1", bus.busy); end
        checks++; if (bus.quad !== 4'b0000) begin errors++; $display("FAIL motion_quad_e1 got=%b exp=0000", bus.quad); end
        run_to(3);
        checks++; if (bus.quad !== 4'b0000) begin errors++; $display("FAIL motion_quad_e3 got=%b exp=0000", bus.quad); end
        run_to(4);
        checks++; if (bus.quad !== 4'b1001) begin errors++; $display("FAIL motion_quad_e4 got=%b exp=1001", bus.quad); end
        run_to(8);
        checks++; if (bus.quad !== 4'b1111) begin errors++; $display("FAIL motion_quad_e8 got=%b exp=1111", bus.quad); end
        run_to(11);
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL motion_busy_e11 got=%b exp=1", bus.busy); end
        run_to(12);
        checks++; if (bus.quad !== 4'b1110) begin errors++; $display("FAIL motion_quad_e12 got=%b exp=1110", bus.quad); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL motion_busy_e12 got=%b exp=0", bus.busy); end
        run_to(16);
        checks++; if (bus.quad !== 4'b1110) begin errors++; $display("FAIL motion_quad_e16 got=%b exp=1110", bus.quad); end
    endtask

    task automatic test_simultaneous();
        do_reset(4);
        set_delta(2, 0); cyc(); idle();
        run_to(3);
        set_delta(1, 0); cyc(); idle();
        checks++; if (bus.quad !== 4'b0001) begin errors++; $display("FAIL simul_quad_e4 got=%b exp=0001", bus.quad); end
        run_to(8);
        checks++; if (bus.quad !== 4'b0011 || bus.busy !== 1'b1) begin errors++; $display("FAIL simul_e8 quad=%b busy=%b exp=0011/1", bus.quad, bus.busy); end
        run_to(12);
        checks++; if (bus.quad !== 4'b0010 || bus.busy !== 1'b0) begin errors++; $display("FAIL simul_e12 quad=%b busy=%b exp=0010/0", bus.quad, bus.busy); end

        do_reset(4);
        set_delta(5, 0); cyc(); idle();
        run_to(4);
        checks++; if (bus.quad !== 4'b0001) begin errors++; $display("FAIL clear_pre_quad got=%b exp=0001", bus.quad); end
        set_delta(7, 0); bus.clear = 1'b1; cyc(); idle();
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL clear_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.quad !== 4'b0001) begin errors++; $display("FAIL clear_phase got=%b exp=0001", bus.quad); end
        run_to(12);
        checks++; if (bus.quad !== 4'b0001 || bus.busy !== 1'b0) begin errors++; $display("FAIL clear_after quad=%b busy=%b exp=0001/0", bus.quad, bus.busy); end
    endtask

    task automatic test_back_to_back();
        do_reset(4);
        set_delta(1, -1); cyc(); cyc(); cyc(); idle();
        checks++; if (bus.quad !== 4'b0000 || bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_e3 quad=%b busy=%b exp=0000/1", bus.quad, bus.busy); end
        run_to(11);
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_busy_e11 got=%b exp=1", bus.busy); end
        run_to(12);
        checks++; if (bus.quad !== 4'b0110 || bus.busy !== 1'b0) begin errors++; $display("FAIL b2b_e12 quad=%b busy=%b exp=0110/0", bus.quad, bus.busy); end
    endtask

    task automatic test_saturation();
        logic [3:0] prev;
        logic [3:0] diff;
        int n0;
        int n1;
        int bad;
        int guard;
        do_reset(60000);
        repeat (17) begin
            set_delta(255, -256);
            cyc();
        end
        idle();
        checks++; if (bus.overflow !== 2'b11) begin errors++; $display("FAIL sat_ovf got=%b exp=11", bus.overflow); end
        bus.step_div = 16'd0;
        cyc();
        checks++; if (bus.quad !== 4'b0000) begin errors++; $display("FAIL sat_wrap_notick quad=%b exp=0000", bus.quad); end
        prev  = bus.quad;
        n0    = 0;
        n1    = 0;
        bad   = 0;
        guard = 0;
        while (bus.busy === 1'b1 && guard < 3000) begin
            cyc();
            guard++;
            diff = bus.quad ^ prev;
            if (diff[1:0] != 2'b00) n0++;
            if (diff[3:2] != 2'b00) n1++;
            if ($countones(diff[1:0]) > 1 || $countones(diff[3:2]) > 1) bad++;
            prev = bus.quad;
        end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL sat_drain_timeout busy=%b exp=0", bus.busy); end
        checks++; if (n0 != 2047) begin errors++; $display("FAIL sat_steps_axis0 got=%0d exp=2047", n0); end
        checks++; if (n1 != 2047) begin errors++; $display("FAIL sat_steps_axis1 got=%0d exp=2047", n1); end
        checks++; if (bad != 0) begin errors++; $display("FAIL sat_single_bit bad=%0d exp=0", bad); end
        checks++; if (bus.quad !== 4'b0110) begin errors++; $display("FAIL sat_final_quad got=%b exp=0110", bus.quad); end
        checks++; if (bus.overflow !== 2'b11) begin errors++; $display("FAIL sat_ovf_sticky got=%b exp=11", bus.overflow); end
        bus.clear = 1'b1; cyc(); bus.clear = 1'b0;
        checks++; if (bus.overflow !== 2'b00) begin errors++; $display("FAIL sat_ovf_clear got=%b exp=00", bus.overflow); end
        checks++; if (bus.quad !== 4'b0110) begin errors++; $display("FAIL sat_clear_phase got=%b exp=0110", bus.quad); end
    endtask

    task automatic test_divider();
        do_reset(100);
        set_delta(5, 0); cyc(); idle();
        run_to(50);
        checks++; if (bus.quad !== 4'b0000) begin errors++; $display("FAIL div_e50 got=%b exp=0000", bus.quad); end
        bus.step_div = 16'd3;
        run_to(53);
        checks++; if (bus.quad !== 4'b0000) begin errors++; $display("FAIL div_wrap_notick got=%b exp=0000", bus.quad); end
        run_to(54);
        checks++; if (bus.quad !== 4'b0001) begin errors++; $display("FAIL div_first_tick got=%b exp=0001", bus.quad); end
        run_to(56);
        checks++; if (bus.quad !== 4'b0001) begin errors++; $display("FAIL div_hold_e56 got=%b exp=0001", bus.quad); end
        run_to(57);
        checks++; if (bus.quad !== 4'b0011) begin errors++; $display("FAIL div_second_tick got=%b exp=0011", bus.quad); end
    endtask

    task automatic test_reset_mid();
        int bad;
        do_reset(4);
        set_delta(40, 0); cyc(); idle();
        run_to(9);
        checks++; if (bus.quad !== 4'b0011 || bus.busy !== 1'b1) begin errors++; $display("FAIL rmid_pre quad=%b busy=%b exp=0011/1", bus.quad, bus.busy); end
        res = 1'b0; cyc(); res = 1'b1;
        checks++; if (bus.quad !== 4'b0000 || bus.busy !== 1'b0 || bus.overflow !== 2'b00) begin errors++; $display("FAIL rmid_reset quad=%b busy=%b ovf=%b exp=0000/0/00", bus.quad, bus.busy, bus.overflow); end
        bad = 0;
        repeat (20) begin
            cyc();
            if (bus.quad !== 4'b0000 || bus.busy !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL rmid_no_edges bad_cycles=%0d exp=0", bad); end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.step_div = 16'd4;
        idle();
        test_reset();
        test_motion();
        test_simultaneous();
        test_back_to_back();
        test_saturation();
        test_divider();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
